// File: rtl/button_pkg.sv
// Shared types for the button event classifier.
// Holds the FSM states, the bundled event struct and a small helper.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    WAIT2,
    PRESSED2,
    LONG_HELD
  } state_t;

  typedef struct packed {
    logic press;
    logic release_p;
    logic click;
    logic dbl;
    logic long_p;
  } btn_events_t;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_classifier_if.sv
// Level-in / event-out bundle between the classifier and its consumer.
// The master drives the button level, the slave reports events.
interface button_event_classifier_if;

  logic level;
  logic press;
  logic rel;
  logic click;
  logic dbl;
  logic long_p;
  logic busy;

  modport master (
    output level,
    input  press,
    input  rel,
    input  click,
    input  dbl,
    input  long_p,
    input  busy
  );

  modport slave (
    input  level,
    output press,
    output rel,
    output click,
    output dbl,
    output long_p,
    output busy
  );

endinterface

// File: rtl/button_tick_gen.sv
// Free-running prescaler producing a one-cycle timing tick.
// Tick is high while the count sits at TICK_DIV-1.
module button_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign o_tick = (cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/button_event_classifier.sv
// Classifies a debounced button level into press/release/click/
// double/long one-cycle event pulses, timed in prescaler ticks.
module button_event_classifier
  import button_pkg::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int LONG_TICKS = 500,
  parameter int DBL_TICKS  = 250
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_double,
  output logic o_long,
  output logic o_busy
);

  localparam int MAXT = max_i(LONG_TICKS, DBL_TICKS);
  localparam int EW   = $clog2(MAXT + 1);
  localparam logic [EW-1:0] LONG_M1 = EW'(LONG_TICKS - 1);
  localparam logic [EW-1:0] DBL_M1  = EW'(DBL_TICKS - 1);
  localparam logic [EW-1:0] SAT     = {EW{1'b1}};

  logic          tick;
  logic          prev_level;
  logic          rise;
  logic          fall;
  logic          long_hit;
  logic          dbl_hit;
  logic [EW-1:0] elapsed;
  state_t        state;
  state_t        state_nx;
  btn_events_t   ev_nx;
  btn_events_t   ev_q;
  logic          busy_q;

  button_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .o_tick (tick)
  );

  assign rise = i_level & ~prev_level;
  assign fall = ~i_level & prev_level;

  // A threshold is hit on the tick that would bring elapsed up to it.
  assign long_hit = tick && (elapsed >= LONG_M1);
  assign dbl_hit  = tick && (elapsed >= DBL_M1);

  always_comb begin
    state_nx = state;
    ev_nx    = '0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          ev_nx.press = 1'b1;
          state_nx    = PRESSED;
        end
      end
      PRESSED: begin
        if (fall) begin
          ev_nx.release_p = 1'b1;
          state_nx        = WAIT2;
        end else if (long_hit) begin
          ev_nx.long_p = 1'b1;
          state_nx     = LONG_HELD;
        end
      end
      WAIT2: begin
        if (rise) begin
          ev_nx.press = 1'b1;
          state_nx    = PRESSED2;
        end else if (dbl_hit) begin
          ev_nx.click = 1'b1;
          state_nx    = IDLE;
        end
      end
      PRESSED2: begin
        if (fall) begin
          ev_nx.release_p = 1'b1;
          ev_nx.dbl       = 1'b1;
          state_nx        = IDLE;
        end else if (long_hit) begin
          ev_nx.long_p = 1'b1;
          state_nx     = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          ev_nx.release_p = 1'b1;
          state_nx        = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_level <= 1'b0;
      state      <= IDLE;
      ev_q       <= '0;
      busy_q     <= 1'b0;
      elapsed    <= '0;
    end else begin
      prev_level <= i_level;
      state      <= state_nx;
      ev_q       <= ev_nx;
      busy_q     <= (state_nx != IDLE);
      // Every transition restarts the timer; the prescaler keeps running.
      if (state_nx != state) begin
        elapsed <= '0;
      end else if (tick && (elapsed != SAT)) begin
        elapsed <= elapsed + 1'b1;
      end
    end
  end

  assign o_press   = ev_q.press;
  assign o_release = ev_q.release_p;
  assign o_click   = ev_q.click;
  assign o_double  = ev_q.dbl;
  assign o_long    = ev_q.long_p;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// Bench for button_event_classifier: directed gestures plus random
// level sequences, checked every cycle against a timestamp model.
module tb_button_event_classifier;

  localparam int D  = 4;
  localparam int L  = 10;
  localparam int DB = 5;

  localparam int M_IDLE = 0;
  localparam int M_DN1  = 1;
  localparam int M_UP1  = 2;
  localparam int M_DN2  = 3;
  localparam int M_LONG = 4;

  logic clk = 1'b0;
  logic rst_n;

  button_event_classifier_if bif ();

  button_event_classifier #(
    .TICK_DIV  (D),
    .LONG_TICKS(L),
    .DBL_TICKS (DB)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_level  (bif.level),
    .o_press  (bif.press),
    .o_release(bif.rel),
    .o_click  (bif.click),
    .o_double (bif.dbl),
    .o_long   (bif.long_p),
    .o_busy   (bif.busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: edges counted since reset; elapsed ticks derived by division.
  int   ecnt = 0;
  int   t_last = 0;
  int   mst = M_IDLE;
  logic prv = 1'b0;
  logic x_press = 1'b0, x_rel = 1'b0, x_click = 1'b0;
  logic x_dbl = 1'b0, x_long = 1'b0, x_busy = 1'b0;

  task automatic mreset();
    ecnt = 0; t_last = 0; mst = M_IDLE; prv = 1'b0;
    x_press = 0; x_rel = 0; x_click = 0;
    x_dbl = 0; x_long = 0; x_busy = 0;
  endtask

  task automatic medge(input logic lvl);
    int   ticks;
    int   ns;
    logic up;
    logic dn;
    ecnt++;
    up  = lvl & ~prv;
    dn  = ~lvl & prv;
    prv = lvl;
    ticks = ecnt / D - t_last / D;
    x_press = 0; x_rel = 0; x_click = 0; x_dbl = 0; x_long = 0;
    ns = mst;
    case (mst)
      M_IDLE: if (up) begin x_press = 1; ns = M_DN1; end
      M_DN1:
        if (dn) begin x_rel = 1; ns = M_UP1; end
        else if (ticks >= L) begin x_long = 1; ns = M_LONG; end
      M_UP1:
        if (up) begin x_press = 1; ns = M_DN2; end
        else if (ticks >= DB) begin x_click = 1; ns = M_IDLE; end
      M_DN2:
        if (dn) begin x_rel = 1; x_dbl = 1; ns = M_IDLE; end
        else if (ticks >= L) begin x_long = 1; ns = M_LONG; end
      default:
        if (dn) begin x_rel = 1; ns = M_IDLE; end
    endcase
    if (ns != mst) t_last = ecnt;
    mst = ns;
    x_busy = (mst != M_IDLE);
  endtask

  always @(negedge rst_n) mreset();

  always @(posedge clk) begin
    #1;
    if (!rst_n) mreset();
    else medge(bif.level);
  end

  // Pulse bookkeeping for the hand-computed gesture checks.
  int ncyc = 0;
  int n_press, n_rel, n_click, n_dbl, n_long;
  int press_cyc, rel_cyc, click_cyc, dbl_cyc, long_cyc;
  int drv_cyc = 0;

  task automatic clr_counts();
    n_press = 0; n_rel = 0; n_click = 0; n_dbl = 0; n_long = 0;
    press_cyc = -1; rel_cyc = -1; click_cyc = -1;
    dbl_cyc = -1; long_cyc = -1;
  endtask

  task automatic chk(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, ncyc, a, e);
    end
  endtask

  task automatic lit(input string nm, input int got, input int lo,
                     input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d..%0d", nm, got, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    chk("press",  bif.press,  x_press);
    chk("rel",    bif.rel,    x_rel);
    chk("click",  bif.click,  x_click);
    chk("dbl",    bif.dbl,    x_dbl);
    chk("long",   bif.long_p, x_long);
    chk("busy",   bif.busy,   x_busy);
    if (bif.press)  begin n_press++; press_cyc = ncyc; end
    if (bif.rel)    begin n_rel++;   rel_cyc   = ncyc; end
    if (bif.click)  begin n_click++; click_cyc = ncyc; end
    if (bif.dbl)    begin n_dbl++;   dbl_cyc   = ncyc; end
    if (bif.long_p) begin n_long++;  long_cyc  = ncyc; end
  end

  task automatic drive(input logic lvl, input int n);
    @(negedge clk);
    #1;
    bif.level = lvl;
    drv_cyc = ncyc;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset(input logic lvl, input int n);
    @(negedge clk);
    #1;
    bif.level = lvl;
    rst_n = 1'b0;
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drv_cyc = ncyc;
  endtask

  int r0;
  int f0;

  initial begin
    rst_n = 1'b1;
    bif.level = 1'b0;
    clr_counts();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Single click
    clr_counts();
    drive(1'b1, 12);
    drive(1'b0, 30); f0 = drv_cyc;
    drive(1'b0, 10);
    lit("s1_press",  n_press, 1, 1);
    lit("s1_rel",    n_rel, 1, 1);
    lit("s1_click",  n_click, 1, 1);
    lit("s1_click_lat", click_cyc - f0, 17, 21);
    lit("s1_nodbl",  n_dbl + n_long, 0, 0);

    // Double click
    clr_counts();
    drive(1'b1, 8); drive(1'b0, 8);
    drive(1'b1, 8); drive(1'b0, 45);
    lit("s2_press", n_press, 2, 2);
    lit("s2_dbl",   n_dbl, 1, 1);
    lit("s2_dbl_with_rel", dbl_cyc - rel_cyc, 0, 0);
    lit("s2_noclick", n_click + n_long, 0, 0);

    // Long press
    clr_counts();
    drive(1'b1, 60); r0 = drv_cyc;
    drive(1'b0, 30);
    lit("s3_long", n_long, 1, 1);
    lit("s3_long_lat", long_cyc - r0, 37, 41);
    lit("s3_rel", n_rel, 1, 1);
    lit("s3_noclick", n_click + n_dbl, 0, 0);

    // Second press held long
    clr_counts();
    drive(1'b1, 8); drive(1'b0, 6);
    drive(1'b1, 60); drive(1'b0, 30);
    lit("s4_long", n_long, 1, 1);
    lit("s4_rel", n_rel, 2, 2);
    lit("s4_noclick", n_click + n_dbl, 0, 0);

    // Reset while waiting for a second press
    clr_counts();
    drive(1'b1, 6); drive(1'b0, 5);
    do_reset(1'b0, 3);
    drive(1'b0, 40);
    lit("s5_noclick", n_click, 0, 0);
    chk("s5_busy", bif.busy, 1'b0);

    // Level already high when reset is released
    drive(1'b0, 5);
    do_reset(1'b1, 3); r0 = drv_cyc;
    clr_counts();
    repeat (59) @(negedge clk);
    drive(1'b0, 20);
    lit("s6_press_lat", press_cyc - r0, 1, 1);
    lit("s6_long", n_long, 1, 1);
    lit("s6_long_lat", long_cyc - r0, 37, 41);

    // Random level sequences with occasional resets
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 29) == 0)
        do_reset(1'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
      else
        drive(~bif.level, int'($urandom_range(1, 50)));
    end
    drive(1'b0, 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
